// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with a valid/ready load port, sof/eof framing,
// a stall input and a programmable idle gap after each frame.
module piso_serializer #(
    parameter int WIDTH      = 4,
    parameter bit MSB_FIRST  = 1'b0,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk1,
    input  logic             rst1,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             hold,
    output logic             sout,
    output logic             sout_valid,
    output logic             sof,
    output logic             eof,
    output logic             busy
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
    localparam logic [3:0]     GAP_LAST = 4'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic [3:0]       r_gap;
    logic             r_load_ready;
    logic             r_sout_valid;
    logic             r_sof;
    logic             r_eof;
    logic             r_busy;

    logic [WIDTH-1:0] w_ordered;
    logic [CW-1:0]    w_cnt_inc;
    logic             w_accept;

    // Reorder the word once at load so the shifter always emits bit 0 next.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_order
        if (MSB_FIRST) begin : g_msb
            assign w_ordered[gi] = data_in[WIDTH-1-gi];
        end else begin : g_lsb
            assign w_ordered[gi] = data_in[gi];
        end
    end

    assign w_accept  = load_valid & r_load_ready;
    assign w_cnt_inc = r_cnt + CW'(1);

    always_ff @(posedge clk1) begin
        if (rst1) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_gap        <= '0;
            r_load_ready <= 1'b1;
            r_sout_valid <= 1'b0;
            r_sof        <= 1'b0;
            r_eof        <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state      <= ST_SHIFT;
                        r_shift      <= w_ordered;
                        r_cnt        <= '0;
                        r_load_ready <= 1'b0;
                        r_sout_valid <= 1'b1;
                        r_sof        <= 1'b1;
                        r_eof        <= 1'b0;
                        r_busy       <= 1'b1;
                    end
                end

                ST_SHIFT: begin
                    if (!hold) begin
                        if (r_cnt == CNT_LAST) begin
                            // Clearing the shifter forces sout low outside a frame.
                            r_shift      <= '0;
                            r_cnt        <= '0;
                            r_sout_valid <= 1'b0;
                            r_sof        <= 1'b0;
                            r_eof        <= 1'b0;
                            if (GAP_CYCLES > 0) begin
                                r_state <= ST_GAP;
                                r_gap   <= '0;
                            end else begin
                                r_state      <= ST_IDLE;
                                r_load_ready <= 1'b1;
                                r_busy       <= 1'b0;
                            end
                        end else begin
                            r_shift <= r_shift >> 1;
                            r_cnt   <= w_cnt_inc;
                            r_sof   <= 1'b0;
                            r_eof   <= (w_cnt_inc == CNT_LAST);
                        end
                    end
                end

                ST_GAP: begin
                    if (r_gap == GAP_LAST) begin
                        r_state      <= ST_IDLE;
                        r_gap        <= '0;
                        r_load_ready <= 1'b1;
                        r_busy       <= 1'b0;
                    end else begin
                        r_gap <= r_gap + 4'd1;
                    end
                end

                default: begin
                    r_state      <= ST_IDLE;
                    r_shift      <= '0;
                    r_cnt        <= '0;
                    r_gap        <= '0;
                    r_load_ready <= 1'b1;
                    r_sout_valid <= 1'b0;
                    r_sof        <= 1'b0;
                    r_eof        <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign load_ready = r_load_ready;
    assign sout       = r_shift[0];
    assign sout_valid = r_sout_valid;
    assign sof        = r_sof;
    assign eof        = r_eof;
    assign busy       = r_busy;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three instances (LSB/gap1, MSB/gap1, LSB/gap0) checked by
// directed vector tables and by a word-level reference model under random stimulus.
module tb_piso_serializer;

    localparam int W = 4;
    localparam int NDUT = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] d_in [NDUT];
    logic         lv   [NDUT];
    logic         hld  [NDUT];
    logic         rdy  [NDUT];
    logic         so   [NDUT];
    logic         sov  [NDUT];
    logic         sf   [NDUT];
    logic         ef   [NDUT];
    logic         bsy  [NDUT];
    logic [5:0]   obs  [NDUT];

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .GAP_CYCLES(1)) dut0 (
        .clk1(clk), .rst1(rst), .data_in(d_in[0]), .load_valid(lv[0]), .load_ready(rdy[0]),
        .hold(hld[0]), .sout(so[0]), .sout_valid(sov[0]), .sof(sf[0]), .eof(ef[0]), .busy(bsy[0]));
    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP_CYCLES(1)) dut1 (
        .clk1(clk), .rst1(rst), .data_in(d_in[1]), .load_valid(lv[1]), .load_ready(rdy[1]),
        .hold(hld[1]), .sout(so[1]), .sout_valid(sov[1]), .sof(sf[1]), .eof(ef[1]), .busy(bsy[1]));
    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) dut2 (
        .clk1(clk), .rst1(rst), .data_in(d_in[2]), .load_valid(lv[2]), .load_ready(rdy[2]),
        .hold(hld[2]), .sout(so[2]), .sout_valid(sov[2]), .sof(sf[2]), .eof(ef[2]), .busy(bsy[2]));

    // Output vector order: {load_ready, sout, sout_valid, sof, eof, busy}
    for (genvar gi = 0; gi < NDUT; gi++) begin : g_obs
        assign obs[gi] = {rdy[gi], so[gi], sov[gi], sf[gi], ef[gi], bsy[gi]};
    end

    task automatic check(input string name, input int idx, input logic [5:0] act,
                         input logic [5:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d t=%0t got=%b want=%b", name, idx, $time, act, exp);
        end
    endtask

    // Word-level reference: a frame is WIDTH bits still to send, then a gap count.
    int         cfg_gap [NDUT] = '{1, 1, 0};
    bit         cfg_msb [NDUT] = '{1'b0, 1'b1, 1'b0};
    logic [W-1:0] m_word [NDUT] = '{default: '0};
    int         m_left [NDUT] = '{default: 0};
    int         m_gap  [NDUT] = '{default: 0};

    function automatic logic [5:0] model_out(input int i);
        int   k;
        logic b;
        if (m_left[i] > 0) begin
            k = W - m_left[i];
            b = cfg_msb[i] ? m_word[i][W-1-k] : m_word[i][k];
            return {1'b0, b, 1'b1, m_left[i] == W, m_left[i] == 1, 1'b1};
        end else if (m_gap[i] > 0) begin
            return 6'b000001;
        end
        return 6'b100000;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            if (rst) begin
                m_left[i] <= 0;
                m_gap[i]  <= 0;
            end else if (m_left[i] > 0) begin
                if (!hld[i]) begin
                    m_left[i] <= m_left[i] - 1;
                    if (m_left[i] == 1) m_gap[i] <= cfg_gap[i];
                end
            end else if (m_gap[i] > 0) begin
                m_gap[i] <= m_gap[i] - 1;
            end else if (lv[i]) begin
                m_word[i] <= d_in[i];
                m_left[i] <= W;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NDUT; i++) check("model", i, obs[i], model_out(i));
        end
    end

    typedef struct {
        int         dut;
        logic       lv;
        logic [3:0] d;
        logic       hold;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int dut, input logic l, input logic [3:0] d, input logic h,
                       input logic [5:0] e);
        vec_t v;
        v.dut = dut; v.lv = l; v.d = d; v.hold = h; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < NDUT; i++) begin
            lv[i]  = 1'b0;
            hld[i] = 1'b0;
        end
    endtask

    initial begin
        // T2: LSB-first 1011, gap 1
        add(0, 1, 4'hB, 0, 6'b100000); add(0, 0, 4'hB, 0, 6'b011101);
        add(0, 0, 4'hB, 0, 6'b011001); add(0, 0, 4'hB, 0, 6'b001001);
        add(0, 0, 4'hB, 0, 6'b011011); add(0, 0, 4'hB, 0, 6'b000001);
        add(0, 0, 4'hB, 0, 6'b100000);
        // T3: MSB-first 1000
        add(1, 1, 4'h8, 0, 6'b100000); add(1, 0, 4'h8, 0, 6'b011101);
        add(1, 0, 4'h8, 0, 6'b001001); add(1, 0, 4'h8, 0, 6'b001001);
        add(1, 0, 4'h8, 0, 6'b001011); add(1, 0, 4'h8, 0, 6'b000001);
        add(1, 0, 4'h8, 0, 6'b100000);
        // T4: 0110 with hold for 3 cycles while bit 1 is shown
        add(0, 1, 4'h6, 0, 6'b100000); add(0, 0, 4'h6, 0, 6'b001101);
        add(0, 0, 4'h6, 1, 6'b011001); add(0, 0, 4'h6, 1, 6'b011001);
        add(0, 0, 4'h6, 1, 6'b011001); add(0, 0, 4'h6, 0, 6'b011001);
        add(0, 0, 4'h6, 0, 6'b011001); add(0, 0, 4'h6, 0, 6'b001011);
        add(0, 0, 4'h6, 0, 6'b000001); add(0, 0, 4'h6, 0, 6'b100000);
        // T5: back-to-back A then 5 with no gap
        add(2, 1, 4'hA, 0, 6'b100000); add(2, 1, 4'h5, 0, 6'b001101);
        add(2, 1, 4'h5, 0, 6'b011001); add(2, 1, 4'h5, 0, 6'b001001);
        add(2, 1, 4'h5, 0, 6'b011011); add(2, 1, 4'h5, 0, 6'b100000);
        add(2, 0, 4'h5, 0, 6'b011101); add(2, 0, 4'h5, 0, 6'b001001);
        add(2, 0, 4'h5, 0, 6'b011001); add(2, 0, 4'h5, 0, 6'b001011);
        add(2, 0, 4'h5, 0, 6'b100000);
        // T6: 0011 accepted with hold high in idle; F pulses while busy are ignored
        add(0, 1, 4'h3, 1, 6'b100000); add(0, 0, 4'h3, 0, 6'b011101);
        add(0, 1, 4'hF, 0, 6'b011001); add(0, 0, 4'hF, 0, 6'b001001);
        add(0, 0, 4'hF, 0, 6'b001011); add(0, 1, 4'hF, 0, 6'b000001);
        add(0, 0, 4'hF, 0, 6'b100000); add(0, 0, 4'hF, 0, 6'b100000);

        rst = 1'b1;
        for (int i = 0; i < NDUT; i++) d_in[i] = '0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) check("reset", i, obs[i], 6'b100000);
        @(posedge clk); #1;

        // T1: reset for 2 cycles mid-frame, then no eof must ever appear
        lv[0] = 1'b1; d_in[0] = 4'hB;
        @(posedge clk); #1 lv[0] = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_midframe", 0, obs[0], 6'b011001);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("t1_after_rst", 0, obs[0], 6'b100000);
            @(posedge clk); #1;
        end

        foreach (tbl[r]) begin
            idle_inputs();
            lv[tbl[r].dut]   = tbl[r].lv;
            d_in[tbl[r].dut] = tbl[r].d;
            hld[tbl[r].dut]  = tbl[r].hold;
            @(negedge clk);
            check($sformatf("tbl%0d", r), tbl[r].dut, obs[tbl[r].dut], tbl[r].exp);
            @(posedge clk); #1;
        end

        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NDUT; i++) begin
                lv[i]   = 1'($urandom_range(0, 1));
                d_in[i] = 4'($urandom);
                hld[i]  = ($urandom_range(0, 3) == 0);
            end
            rst = ($urandom_range(0, 299) == 0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        idle_inputs();
        repeat (12) @(posedge clk);
        #1;
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) check("drain_idle", i, obs[i], 6'b100000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
